// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared constants for the next-PC controller (cpu_defs).
// Revision : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // PC mux select codes; zero input of the mux is tied high
    localparam logic [7:0] c_pc_next     = 8'h01;
    localparam logic [7:0] c_pc_branch8  = 8'h02;
    localparam logic [7:0] c_pc_branch11 = 8'h03;
    localparam logic [7:0] c_pc_jump     = 8'h04;
    localparam logic [7:0] c_pc_epcret   = 8'h05;
    localparam logic [7:0] c_pc_intjump  = 8'h28;

    // Control-transfer codes carried by the EX stage
    localparam logic [2:0] c_ex_none = 3'd0;
    localparam logic [2:0] c_ex_beqz = 3'd1;
    localparam logic [2:0] c_ex_bnez = 3'd2;
    localparam logic [2:0] c_ex_b    = 3'd3;
    localparam logic [2:0] c_ex_jr   = 3'd4;
    localparam logic [2:0] c_ex_eret = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_VECTOR = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Pipeline <-> next-PC controller signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic [15:0] if_pc;
    logic [2:0]  ex_ctrl;
    logic        ex_zero;
    logic        id_is_ctrl;
    logic        hazard_stall;
    logic        mem_conflict;
    logic        int_req;
    logic [7:0]  pc_src;
    logic        pc_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [15:0] epc;
    logic        int_ack;
    logic        int_active;

    modport master (
        output if_pc, ex_ctrl, ex_zero, id_is_ctrl, hazard_stall, mem_conflict, int_req,
        input  pc_src, pc_we, if_id_flush, id_ex_flush, epc, int_ack, int_active
    );

    modport slave (
        input  if_pc, ex_ctrl, ex_zero, id_is_ctrl, hazard_stall, mem_conflict, int_req,
        output pc_src, pc_we, if_id_flush, id_ex_flush, epc, int_ack, int_active
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Brief    : Maps the EX control-transfer code to taken/PC-mux select.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] ex_ctrl,
    input  logic       ex_zero,
    output logic       taken,
    output logic [7:0] pc_src
);

    always_comb begin
        taken  = 1'b0;
        pc_src = c_pc_next;
        case (ex_ctrl)
            c_ex_beqz: begin taken = ex_zero;  pc_src = c_pc_branch8;  end
            c_ex_bnez: begin taken = !ex_zero; pc_src = c_pc_branch8;  end
            c_ex_b:    begin taken = 1'b1;     pc_src = c_pc_branch11; end
            c_ex_jr:   begin taken = 1'b1;     pc_src = c_pc_jump;     end
            c_ex_eret: begin taken = 1'b1;     pc_src = c_pc_epcret;   end
            default:   ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Next-PC controller: redirects, stalls, interrupt entry, EPC.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] INT_VECTOR   = 16'h0005,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam logic [2:0] c_drain_load = 3'(DRAIN_CYCLES - 1);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] r_epc;
    logic        r_int_active;

    logic        w_taken;
    logic [7:0]  w_br_src;
    logic        w_entry;
    logic        w_epc_we;
    logic        w_set_active;
    logic        w_clr_active;
    logic [7:0]  w_pc_src;
    logic        w_pc_we;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;
    logic        w_int_ack;

    // The vector address itself lives in the PC mux; the parameter is shared with it
    logic [15:0] w_unused_vector;
    assign w_unused_vector = INT_VECTOR;

    branch_resolve u_branch_resolve (
        .ex_ctrl (bus.ex_ctrl),
        .ex_zero (bus.ex_zero),
        .taken   (w_taken),
        .pc_src  (w_br_src)
    );

    assign w_entry = bus.int_req && !r_int_active && !bus.id_is_ctrl &&
                     (bus.ex_ctrl == c_ex_none) && !bus.mem_conflict && !bus.hazard_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_cnt        <= 3'd0;
            r_epc        <= 16'h0000;
            r_int_active <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_epc_we)
                r_epc <= bus.if_pc;
            if (w_set_active)
                r_int_active <= 1'b1;
            else if (w_clr_active)
                r_int_active <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_epc_we      = 1'b0;
        w_set_active  = 1'b0;
        w_clr_active  = 1'b0;
        w_pc_src      = c_pc_next;
        w_pc_we       = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_int_ack     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_pc_src      = w_br_src;
                    w_pc_we       = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_clr_active  = (bus.ex_ctrl == c_ex_eret);
                end else if (w_entry) begin
                    w_epc_we      = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_cnt_nxt     = c_drain_load;
                    w_state_nxt   = ST_DRAIN;
                end else if (bus.mem_conflict) begin
                    w_if_id_flush = 1'b1;
                end else if (bus.hazard_stall) begin
                    w_id_ex_flush = 1'b1;
                end else begin
                    w_pc_we = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Stalls are irrelevant here: only bubbles are in flight
                w_if_id_flush = 1'b1;
                if (r_cnt == 3'd0)
                    w_state_nxt = ST_VECTOR;
                else
                    w_cnt_nxt = r_cnt - 3'd1;
            end
            ST_VECTOR: begin
                w_pc_src      = c_pc_intjump;
                w_pc_we       = 1'b1;
                w_int_ack     = 1'b1;
                w_if_id_flush = 1'b1;
                w_set_active  = 1'b1;
                w_state_nxt   = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Hold the pipeline quiet for the whole asynchronous reset pulse
        if (rst) begin
            w_pc_src      = c_pc_next;
            w_pc_we       = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_int_ack     = 1'b0;
        end
    end

    assign bus.pc_src      = w_pc_src;
    assign bus.pc_we       = w_pc_we;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.int_ack     = w_int_ack;
    assign bus.epc         = r_epc;
    assign bus.int_active  = r_int_active;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer with a behavioural PC register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [15:0] INT_VECTOR   = 16'h0005;
    localparam int unsigned DRAIN_CYCLES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .INT_VECTOR   (INT_VECTOR),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PC register and mux of the surrounding pipeline
    logic [15:0] pc_model = 16'h0000;
    logic [15:0] target   = 16'h0000;
    assign bus.if_pc = pc_model;

    always @(posedge clk) begin
        if (!rst && bus.pc_we) begin
            case (bus.pc_src)
                c_pc_next:     pc_model <= pc_model + 16'd1;
                c_pc_branch8,
                c_pc_branch11,
                c_pc_jump:     pc_model <= target;
                c_pc_epcret:   pc_model <= bus.epc;
                c_pc_intjump:  pc_model <= INT_VECTOR;
                default:       pc_model <= 16'hDEAD;
            endcase
        end
    end

    typedef struct {
        string       tag;
        logic [7:0]  src;
        logic        we, f1, f2, ack, act;
        logic [15:0] epc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if ({bus.pc_src, bus.pc_we, bus.if_id_flush, bus.id_ex_flush, bus.int_ack,
                 bus.int_active, bus.epc} !==
                {mon_e.src, mon_e.we, mon_e.f1, mon_e.f2, mon_e.ack, mon_e.act, mon_e.epc}) begin
                n_fail++;
                $display("FAIL %s t=%0t: got src=%h we=%b ifid=%b idex=%b ack=%b act=%b epc=%h, want src=%h we=%b ifid=%b idex=%b ack=%b act=%b epc=%h",
                         mon_e.tag, $time, bus.pc_src, bus.pc_we, bus.if_id_flush, bus.id_ex_flush,
                         bus.int_ack, bus.int_active, bus.epc, mon_e.src, mon_e.we, mon_e.f1,
                         mon_e.f2, mon_e.ack, mon_e.act, mon_e.epc);
            end
        end
    end

    task automatic drive(input logic [2:0] ctrl, input logic zero, input logic idc,
                         input logic hz, input logic mc, input logic irq);
        @(posedge clk);
        #1;
        bus.ex_ctrl      = ctrl;
        bus.ex_zero      = zero;
        bus.id_is_ctrl   = idc;
        bus.hazard_stall = hz;
        bus.mem_conflict = mc;
        bus.int_req      = irq;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] src, input logic we,
                              input logic f1, input logic f2, input logic ack,
                              input logic act, input logic [15:0] epc);
        exp_t e;
        e.tag = tag; e.src = src; e.we = we; e.f1 = f1; e.f2 = f2;
        e.ack = ack; e.act = act; e.epc = epc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        drive(c_ex_none, 0, 0, 0, 0, 0);
        expect_out("reset_out", c_pc_next, 0, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut.r_state !== ST_RUN || dut.r_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d cnt=%0d, want 0/0", dut.r_state, dut.r_cnt);
        end
        expect_out("reset_out2", c_pc_next, 0, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        rst = 1'b0;
        expect_out("run_idle", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_branch();
        drive(c_ex_beqz, 1, 0, 1, 0, 0);
        target = 16'h0020;
        expect_out("beqz_taken_stall", c_pc_branch8, 1, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_jr, 0, 0, 0, 0, 0);
        n_checks++;
        if (pc_model !== 16'h0020) begin
            n_fail++;
            $display("FAIL beqz_target: pc=%h want 0020", pc_model);
        end
        target = 16'h0030;
        expect_out("jr_taken", c_pc_jump, 1, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        n_checks++;
        if (pc_model !== 16'h0030) begin
            n_fail++;
            $display("FAIL jr_target: pc=%h want 0030", pc_model);
        end
        expect_out("after_jr", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_not_taken();
        drive(c_ex_bnez, 1, 0, 0, 0, 0);
        expect_out("bnez_not_taken", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
        drive(c_ex_beqz, 0, 0, 1, 0, 0);
        expect_out("beqz_nt_stall", c_pc_next, 0, 0, 1, 0, 0, 16'h0000);
    endtask

    task automatic test_conflict();
        drive(c_ex_none, 0, 0, 1, 1, 0);
        expect_out("conflict_stall", c_pc_next, 0, 1, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_interrupt();
        drive(c_ex_b, 0, 0, 0, 0, 0);
        target = 16'h0040;
        expect_out("b_to_40", c_pc_branch11, 1, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 0, 0, 1);
        n_checks++;
        if (pc_model !== 16'h0040) begin
            n_fail++;
            $display("FAIL b_target: pc=%h want 0040", pc_model);
        end
        expect_out("int_entry", c_pc_next, 0, 1, 0, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 1, 1, 1);
        expect_out("drain1_ignore", c_pc_next, 0, 1, 0, 0, 0, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        expect_out("drain2_req_low", c_pc_next, 0, 1, 0, 0, 0, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        expect_out("drain3", c_pc_next, 0, 1, 0, 0, 0, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 1);
        expect_out("vector", c_pc_intjump, 1, 1, 0, 1, 0, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 1);
        n_checks++;
        if (pc_model !== INT_VECTOR) begin
            n_fail++;
            $display("FAIL vector_pc: pc=%h want %h", pc_model, INT_VECTOR);
        end
        expect_out("masked_req", c_pc_next, 1, 0, 0, 0, 1, 16'h0040);
        drive(c_ex_eret, 0, 0, 0, 0, 1);
        expect_out("eret", c_pc_epcret, 1, 1, 1, 0, 1, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 1);
        n_checks++;
        if (pc_model !== 16'h0040) begin
            n_fail++;
            $display("FAIL eret_return: pc=%h want 0040", pc_model);
        end
        expect_out("reentry_after_eret", c_pc_next, 0, 1, 0, 0, 0, 16'h0040);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        expect_out("drain_before_rst", c_pc_next, 0, 1, 0, 0, 0, 16'h0040);
    endtask

    task automatic test_reset_mid_drain();
        drive(c_ex_none, 0, 0, 0, 0, 0);
        rst = 1'b1;
        expect_out("rst_mid_drain", c_pc_next, 0, 1, 1, 0, 0, 16'h0000);
        #1;
        n_checks++;
        if (dut.r_state !== ST_RUN) begin
            n_fail++;
            $display("FAIL rst_mid_state: got state=%0d want 0", dut.r_state);
        end
        drive(c_ex_none, 0, 0, 0, 0, 0);
        rst = 1'b0;
        expect_out("post_rst_run", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic test_defer();
        drive(c_ex_jr, 0, 0, 0, 0, 0);
        target = 16'h0100;
        expect_out("jr_to_100", c_pc_jump, 1, 1, 1, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 1, 0, 0, 1);
        n_checks++;
        if (pc_model !== 16'h0100) begin
            n_fail++;
            $display("FAIL jr100_target: pc=%h want 0100", pc_model);
        end
        expect_out("defer_id_ctrl", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
        drive(c_ex_beqz, 0, 0, 0, 0, 1);
        expect_out("defer_ex_ctrl", c_pc_next, 1, 0, 0, 0, 0, 16'h0000);
        drive(c_ex_none, 0, 0, 0, 0, 1);
        expect_out("defer_entry", c_pc_next, 0, 1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < int'(DRAIN_CYCLES); i++) begin
            drive(c_ex_none, 0, 0, 0, 0, 1);
            expect_out("defer_drain", c_pc_next, 0, 1, 0, 0, 0, 16'h0102);
        end
        drive(c_ex_none, 0, 0, 0, 0, 1);
        expect_out("defer_vector", c_pc_intjump, 1, 1, 0, 1, 0, 16'h0102);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        expect_out("handler_run", c_pc_next, 1, 0, 0, 0, 1, 16'h0102);
        drive(c_ex_eret, 0, 0, 0, 0, 0);
        expect_out("defer_eret", c_pc_epcret, 1, 1, 1, 0, 1, 16'h0102);
    endtask

    task automatic test_eret_inactive();
        drive(c_ex_none, 0, 0, 0, 0, 0);
        n_checks++;
        if (pc_model !== 16'h0102) begin
            n_fail++;
            $display("FAIL defer_return: pc=%h want 0102", pc_model);
        end
        expect_out("after_eret_idle", c_pc_next, 1, 0, 0, 0, 0, 16'h0102);
        drive(c_ex_eret, 0, 0, 0, 0, 0);
        expect_out("eret_inactive", c_pc_epcret, 1, 1, 1, 0, 0, 16'h0102);
        drive(c_ex_none, 0, 0, 0, 0, 0);
        n_checks++;
        if (pc_model !== 16'h0102) begin
            n_fail++;
            $display("FAIL eret_inactive_pc: pc=%h want 0102", pc_model);
        end
        expect_out("still_inactive", c_pc_next, 1, 0, 0, 0, 0, 16'h0102);
    endtask

    initial begin
        bus.ex_ctrl      = c_ex_none;
        bus.ex_zero      = 1'b0;
        bus.id_is_ctrl   = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.mem_conflict = 1'b0;
        bus.int_req      = 1'b0;

        test_reset();
        test_branch();
        test_not_taken();
        test_conflict();
        test_interrupt();
        test_reset_mid_drain();
        test_defer();
        test_eret_inactive();

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the 16-bit five-stage pipeline. Each cycle it resolves the PC source from the EX-stage control-transfer result, load-use stalls, fetch/data memory conflicts and the external interrupt request. It drives the PC mux select, the PC write enable and the pipeline-register flushes. It also runs the interrupt-entry state machine and owns the EPC and interrupt-active state.

## Interface
Parameters:
- INT_VECTOR, 16'h0005: interrupt handler entry address; the PC mux hard-wires the same value for the INTJUMP select.
- DRAIN_CYCLES, 3: number of bubble cycles inserted before vectoring. Legal range is 1–7.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset; one clock, asynchronous, active-high.
- if_pc, in, 16: address currently being fetched.
- ex_ctrl, in, 3: control transfer in EX. 0 = none, 1 = BEQZ, 2 = BNEZ, 3 = B, 4 = JR, 5 = ERET.
- ex_zero, in, 1: EX source register == 0.
- id_is_ctrl, in, 1: instruction in ID is a branch, jump or ERET.
- hazard_stall, in, 1: load-use stall request from the hazard unit.
- mem_conflict, in, 1: data access targets instruction RAM this cycle, so the fetch is blocked.
- int_req, in, 1: level interrupt request, held until int_ack.
- pc_src, out, 8: mux select. NEXT = 8'h01, BRANCH8 = 8'h02, BRANCH11 = 8'h03, JUMP = 8'h04, EPCRET = 8'h05, INTJUMP = 8'h28. The mux's zero input is tied high.
- pc_we, out, 1: PC register load enable.
- if_id_flush, out, 1: insert a bubble into IF/ID.
- id_ex_flush, out, 1: insert a bubble into ID/EX.
- epc, out, 16: saved return address, registered. The mux uses it for EPCRET.
- int_ack, out, 1: one-cycle acknowledge in the VECTOR cycle.
- int_active, out, 1: handler running; masks further entries.

## Operation
States are RUN, DRAIN and VECTOR. The state register is 2 bits and uses a 3-bit drain counter.

In RUN, the first matching rule wins:

1. Taken redirect. A redirect is taken when:
   - ex_ctrl = 1 and ex_zero = 1, or
   - ex_ctrl = 2 and ex_zero = 0, or
   - ex_ctrl is 3, 4 or 5.
   Outputs: pc_src = BRANCH8 for codes 1 and 2, BRANCH11 for code 3, JUMP for code 4, EPCRET for code 5. Also pc_we = 1, if_id_flush = 1, id_ex_flush = 1. This rule wins over hazard_stall and mem_conflict. ERET also clears int_active on the next edge.
2. Not-taken conditional branch falls through to the rules below.
3. mem_conflict: pc_src = NEXT, pc_we = 0, if_id_flush = 1.
4. hazard_stall: pc_src = NEXT, pc_we = 0, id_ex_flush = 1, no IF/ID flush.
5. Otherwise: pc_src = NEXT, pc_we = 1.

Interrupt entry:
- Entry condition: int_req = 1 and int_active = 0 and id_is_ctrl = 0 and ex_ctrl = 0 and mem_conflict = 0 and hazard_stall = 0.
- In the entry cycle: epc ← if_pc, pc_we = 0, if_id_flush = 1, counter ← DRAIN_CYCLES − 1, next state DRAIN.
- If the condition fails, entry is deferred. int_req stays asserted.

DRAIN:
- Outputs: pc_we = 0, if_id_flush = 1, pc_src = NEXT.
- The counter decrements each cycle. At 0 the next state is VECTOR.
- EX cannot hold a control transfer in this state, so none is expected.
- hazard_stall and mem_conflict are ignored in DRAIN.

VECTOR (one cycle):
- Outputs: pc_src = INTJUMP, pc_we = 1, int_ack = 1, if_id_flush = 1.
- int_active is set on the edge. Next state RUN.

Other rules:
- pc_src, pc_we, flushes and int_ack are combinational from state and inputs.
- epc, int_active, state and counter are registered.
- epc is written only in the entry cycle.

## Timing
- Reset, while rst is high:
  - state = RUN, counter = 0, epc = 16'h0000, int_active = 0.
  - Combinational outputs are forced to pc_we = 0, pc_src = NEXT, if_id_flush = 1, id_ex_flush = 1, int_ack = 0.
- Reset mid-DRAIN or mid-VECTOR aborts the entry. epc returns to 0.
- Redirect takes effect on the same edge: the PC loads the target, and two wrong-path instructions are flushed.
- Interrupt latency from the entry cycle: the entry cycle, then DRAIN_CYCLES DRAIN cycles, then VECTOR. With the default, the PC equals 16'h0005 after the 5th edge.
- If int_req drops during DRAIN, the entry still completes. Once entered, an entry is committed.
- ERET in EX while int_active = 0 still redirects to epc, and int_active stays 0.
- If int_req is high with int_active = 1, no entry occurs until the ERET edge clears int_active. The earliest entry is the cycle after.

## Structure
- A shared package (the cpu_defs constants file) holds:
  - the pc_src code constants (NEXT, BRANCH8, BRANCH11, JUMP, EPCRET, INTJUMP),
  - the ex_ctrl codes,
  - the state encodings.
- The existing PC mux gains an EPCRET case that selects epc.
- Sub-modules:
  - The redirect-resolution logic goes in one sub-module, branch_resolve: a combinational map from ex_ctrl and ex_zero to taken and pc_src.
  - The FSM, counter and EPC stay in the top-level module.

## Test plan
- BEQZ with ex_zero = 1 in EX, while hazard_stall = 1 in the same cycle -> pc_src = 8'h02, pc_we = 1, both flushes = 1. The stall is ignored.
- BNEZ with ex_zero = 1 -> not taken. pc_src = 8'h01, pc_we = 1, no flush.
- mem_conflict = 1 and hazard_stall = 1 together -> pc_we = 0, if_id_flush = 1, id_ex_flush = 0.
- if_pc = 16'h0040, int_req = 1, all clear -> epc = 16'h0040.
  - Three DRAIN cycles follow with pc_we = 0.
  - Then VECTOR: pc_src = 8'h28, int_ack = 1, int_active = 1.
- int_req raised while id_is_ctrl = 1 -> entry deferred. Entry occurs the first cycle id_is_ctrl = 0 and ex_ctrl = 0.
- During the handler, ERET in EX -> pc_src = 8'h05 and the PC returns to 16'h0040. int_active = 0 on the next edge. rst asserted mid-DRAIN -> epc = 0, state = RUN.
